// File: rtl/serial_subtractor_pkg.sv
// ============================================================================
// serial_subtractor_pkg : state encoding and WIDTH legality for serial_subtractor
// Revision: 1.0
// ============================================================================
`default_nettype none

package serial_subtractor_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_e;

  function automatic bit width_is_legal(input int w);
    return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_subtractor_full_subtractor.sv
// ============================================================================
// full_subtractor : single-bit combinational subtractor cell (x - y - bin)
// Revision: 1.0
// ============================================================================
`default_nettype none

module full_subtractor
  import serial_subtractor_pkg::*;
(
  input  logic x_i,
  input  logic y_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o
);

  assign d_o    = x_i ^ y_i ^ bin_i;
  assign bout_o = (~x_i & y_i) | (~(x_i ^ y_i) & bin_i);

endmodule

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ============================================================================
// serial_subtractor : bit-serial WIDTH-bit a - b, LSB first, start/busy/done.
// Optional signed overflow output ovf_o when SERIAL_SUB_SIGNED_OVF_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] diff_o,
  output logic             borrow_out_o
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  ,
  output logic             ovf_o
`endif
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  if (!width_is_legal(WIDTH)) begin : g_width_check
    $error("serial_subtractor: WIDTH must lie in 2..32");
  end

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  // Only the upper WIDTH-1 result bits are stored; the final d completes diff.
  logic [WIDTH-2:0]     res_q, res_d;
  logic                 borrow_q, borrow_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [WIDTH-1:0]     diff_q, diff_d;
  logic                 bout_q, bout_d;
  logic [WIDTH-1:0]     res_shift;
  logic                 cell_d;
  logic                 cell_bout;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  logic                 a_msb_q, a_msb_d;
  logic                 b_msb_q, b_msb_d;
  logic                 ovf_q, ovf_d;
`endif

  full_subtractor u_cell (
    .x_i    (a_q[0]),
    .y_i    (b_q[0]),
    .bin_i  (borrow_q),
    .d_o    (cell_d),
    .bout_o (cell_bout)
  );

  assign res_shift = {cell_d, res_q};

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    ovf_d    = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          a_d      = a_i;
          b_d      = b_i;
          borrow_d = 1'b0;
          cnt_d    = '0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
          a_msb_d  = a_i[WIDTH-1];
          b_msb_d  = b_i[WIDTH-1];
`endif
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        res_d    = res_shift[WIDTH-1:1];
        borrow_d = cell_bout;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          diff_d  = res_shift;
          bout_d  = cell_bout;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
          ovf_d   = (a_msb_q != b_msb_q) && (cell_d != a_msb_q);
`endif
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign diff_o       = diff_q;
  assign borrow_out_o = bout_q;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  assign ovf_o        = ovf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ============================================================================
// tb_serial_subtractor : directed + random checks of serial_subtractor (WIDTH=8)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  logic             ovf;
`endif

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] held_diff;
  logic             held_bout;
  logic             held_ovf;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start),
    .a_i          (a),
    .b_i          (b),
    .busy_o       (busy),
    .done_o       (done),
    .diff_o       (diff),
    .borrow_out_o (bout)
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    ,
    .ovf_o        (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  task automatic ref_sub(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                         output logic [WIDTH-1:0] d, output logic bo, output logic ov);
    int r;
    int sr;
    r  = int'(x) - int'(y);
    d  = WIDTH'(r);
    bo = (int'(x) < int'(y));
    sr = int'($signed(x)) - int'($signed(y));
    ov = (sr > 127) || (sr < -128);
  endtask

  task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_, input bit noise);
    logic [WIDTH-1:0] ed;
    logic             eb;
    logic             eo;
    int               edges;
    ref_sub(ta, tb_, ed, eb, eo);
    start = 1'b1;
    a     = ta;
    b     = tb_;
    @(posedge clk); #1;
    if (noise) begin
      a = 8'hAA;
      b = 8'h55;
    end else begin
      start = 1'b0;
      a     = 8'($urandom);
      b     = 8'($urandom);
    end
    edges = 0;
    while (done !== 1'b1 && edges < 3 * WIDTH) begin
      check("busy_run", 32'(busy), 32'd1);
      check("diff_hold", 32'(diff), 32'(held_diff));
      check("bout_hold", 32'(bout), 32'(held_bout));
      @(posedge clk); #1;
      edges++;
    end
    check("latency", 32'(edges), 32'(WIDTH));
    check("done_pulse", 32'(done), 32'd1);
    check("busy_done", 32'(busy), 32'd1);
    check("diff", 32'(diff), 32'(ed));
    check("borrow_out", 32'(bout), 32'(eb));
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    check("ovf", 32'(ovf), 32'(eo));
`endif
    held_diff = ed;
    held_bout = eb;
    held_ovf  = eo;
    @(posedge clk); #1;
    start = 1'b0;
    check("done_single", 32'(done), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
    check("diff_kept", 32'(diff), 32'(held_diff));
  endtask

  initial begin
    logic [WIDTH-1:0] qa[$];
    logic [WIDTH-1:0] qb[$];
    logic [WIDTH-1:0] xa, xb, ed;
    logic             eb, eo;

    rst_n     = 1'b0;
    start     = 1'b0;
    a         = '0;
    b         = '0;
    held_diff = '0;
    held_bout = 1'b0;
    held_ovf  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    check("rst_ovf", 32'(ovf), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(8'h5A, 8'h3C, 1'b0);
    run_op(8'h00, 8'h01, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b0);
    run_op(8'h10, 8'h01, 1'b1);
    repeat (6) run_op(8'($urandom), 8'($urandom), 1'b0);
    run_op(8'h40, 8'h07, 1'b0);

    // Asynchronous abort in the middle of a RUN.
    start = 1'b1;
    a     = 8'hC3;
    b     = 8'h21;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_diff", 32'(diff), 32'd0);
    check("abort_bout", 32'(bout), 32'd0);
    #2;
    rst_n     = 1'b1;
    held_diff = '0;
    held_bout = 1'b0;
    held_ovf  = 1'b0;
    @(posedge clk); #1;
    check("post_abort_busy", 32'(busy), 32'd0);
    run_op(8'h03, 8'h05, 1'b0);

`ifdef SERIAL_SUB_SIGNED_OVF_EN
    run_op(8'h80, 8'h01, 1'b0);
    run_op(8'h7F, 8'hFF, 1'b0);
    run_op(8'h05, 8'h03, 1'b0);
`endif

    // start held high: accepts only from IDLE, one operation per WIDTH+2 cycles.
    start = 1'b1;
    for (int c = 0; c < 5 * (WIDTH + 2); c++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      if (c % (WIDTH + 2) == 0) begin
        qa.push_back(a);
        qb.push_back(b);
      end
      @(posedge clk); #1;
      if (c % (WIDTH + 2) == WIDTH) begin
        xa = qa.pop_front();
        xb = qb.pop_front();
        ref_sub(xa, xb, ed, eb, eo);
        check("b2b_done", 32'(done), 32'd1);
        check("b2b_diff", 32'(diff), 32'(ed));
        check("b2b_bout", 32'(bout), 32'(eb));
      end else begin
        check("b2b_nodone", 32'(done), 32'd0);
      end
    end
    start = 1'b0;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
